// File: rtl/nrzi_stuff_encoder.sv
// nrzi_stuff_encoder: USB transmit bit encoder (bit stuffing, NRZI, EOP = SE0 x N then J).
// Latency: a bit accepted on a bit_tick edge drives enc_bit from that edge until the next tick.
// Backpressure: tx_ready is combinational, high only on bit_tick in IDLE/DATA; low on stuff and EOP bit times.
//
// Optional feature macro: NRZI_TX_STUFF_EN -- when defined, a 0 is inserted after
// STUFF_LIMIT consecutive ones; when undefined there is no stuffing logic at all.
//
// Ports:
//   clk, nRST                  clock, asynchronous active-low reset
//   bit_tick                   one-cycle strobe per USB bit time; state only moves on it
//   tx_valid/tx_bit/tx_last    upstream serial bit, last-bit qualifier
//   tx_ready                   combinational accept, transfer = tx_valid & tx_ready
//   enc_bit                    registered NRZI line level (1 = J/idle)
//   se0                        registered SE0 request to the line driver
//   tx_active                  registered, first accepted bit through final J
//   tx_err                     registered one-cycle underrun pulse
module nrzi_stuff_encoder #(
  parameter int STUFF_LIMIT  = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic clk,
  input  logic nRST,
  input  logic bit_tick,
  input  logic tx_valid,
  input  logic tx_bit,
  input  logic tx_last,
  output logic tx_ready,
  output logic enc_bit,
  output logic se0,
  output logic tx_active,
  output logic tx_err
);

  if (STUFF_LIMIT < 2 || STUFF_LIMIT > 15) begin : g_bad_stuff_limit
    $error("nrzi_stuff_encoder: STUFF_LIMIT must be 2..15");
  end
  if (EOP_SE0_BITS < 1 || EOP_SE0_BITS > 3) begin : g_bad_se0_bits
    $error("nrzi_stuff_encoder: EOP_SE0_BITS must be 1..3");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
`ifdef NRZI_TX_STUFF_EN
    S_STUFF,
`endif
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  localparam logic [1:0] SE0_LAST = 2'(EOP_SE0_BITS - 1);

`ifdef NRZI_TX_STUFF_EN
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam logic [OW-1:0] LIMIT_V = OW'(STUFF_LIMIT);

  logic [OW-1:0] ones_q, ones_d, ones_inc;
  // Remembers that the bit which triggered a stuff was the packet's last bit.
  logic          last_q, last_d;
`endif

  state_t     state_q, state_d;
  logic       enc_q, enc_d;
  logic       se0_q, se0_d;
  logic       active_q, active_d;
  logic       err_q, err_d;
  logic [1:0] cnt_q, cnt_d;
  logic       xfer;

  assign tx_ready = bit_tick & ((state_q == S_IDLE) | (state_q == S_DATA));
  assign xfer     = tx_valid & tx_ready;

`ifdef NRZI_TX_STUFF_EN
  assign ones_inc = ones_q + 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    enc_d    = enc_q;
    se0_d    = se0_q;
    active_d = active_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
`ifdef NRZI_TX_STUFF_EN
    ones_d   = ones_q;
    last_d   = last_q;
`endif
    if (bit_tick) begin
      case (state_q)
        S_IDLE, S_DATA: begin
          if (xfer) begin
            // NRZI: a 0 toggles the line, a 1 holds it.
            enc_d    = tx_bit ? enc_q : ~enc_q;
            active_d = 1'b1;
            state_d  = tx_last ? S_EOP_SE0 : S_DATA;
`ifdef NRZI_TX_STUFF_EN
            ones_d = tx_bit ? ones_inc : '0;
            last_d = tx_last;
            if (tx_bit && (ones_inc == LIMIT_V)) begin
              state_d = S_STUFF;
            end
`endif
          end else if (state_q == S_DATA) begin
            // Underrun: line holds for this bit time, EOP starts on the next tick.
            err_d   = 1'b1;
            state_d = S_EOP_SE0;
          end else begin
            active_d = 1'b0;
            enc_d    = 1'b1;
            se0_d    = 1'b0;
          end
        end
`ifdef NRZI_TX_STUFF_EN
        S_STUFF: begin
          enc_d   = ~enc_q;
          ones_d  = '0;
          last_d  = 1'b0;
          state_d = last_q ? S_EOP_SE0 : S_DATA;
        end
`endif
        S_EOP_SE0: begin
          se0_d = 1'b1;
          enc_d = 1'b1;
          if (cnt_q == SE0_LAST) begin
            cnt_d   = '0;
            state_d = S_EOP_J;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        S_EOP_J: begin
          // tx_active stays high through J; it drops on the next idle tick.
          se0_d   = 1'b0;
          enc_d   = 1'b1;
          state_d = S_IDLE;
`ifdef NRZI_TX_STUFF_EN
          ones_d  = '0;
`endif
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      enc_q    <= 1'b1;
      se0_q    <= 1'b0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
`ifdef NRZI_TX_STUFF_EN
      ones_q   <= '0;
      last_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      enc_q    <= enc_d;
      se0_q    <= se0_d;
      active_q <= active_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
`ifdef NRZI_TX_STUFF_EN
      ones_q   <= ones_d;
      last_q   <= last_d;
`endif
    end
  end

  assign enc_bit   = enc_q;
  assign se0       = se0_q;
  assign tx_active = active_q;
  assign tx_err    = err_q;

endmodule

// File: tb/tb_nrzi_stuff_encoder.sv
// tb_nrzi_stuff_encoder: bench for the USB TX bit encoder.
// Builds the expected per-bit-time line sequence of each packet from the encoding rules,
// drives upstream from that sequence, and checks all outputs every clock.
module tb_nrzi_stuff_encoder;

  localparam int LIM  = 6;
  localparam int NSE0 = 2;
`ifdef NRZI_TX_STUFF_EN
  localparam bit STUFF_ON = 1'b1;
`else
  localparam bit STUFF_ON = 1'b0;
`endif

  localparam int F_ENC = 0;
  localparam int F_SE0 = 1;
  localparam int F_RDY = 2;
  localparam int F_ERR = 3;

  logic clk = 1'b0;
  logic nRST, bit_tick, tx_valid, tx_bit, tx_last;
  logic tx_ready, enc_bit, se0, tx_active, tx_err;

  always #5 clk = ~clk;

  nrzi_stuff_encoder #(
    .STUFF_LIMIT (LIM),
    .EOP_SE0_BITS(NSE0)
  ) dut (
    .clk      (clk),
    .nRST     (nRST),
    .bit_tick (bit_tick),
    .tx_valid (tx_valid),
    .tx_bit   (tx_bit),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .enc_bit  (enc_bit),
    .se0      (se0),
    .tx_active(tx_active),
    .tx_err   (tx_err)
  );

  // One entry per bit time: what upstream offers on that tick, the tx_ready expected
  // during it, and the outputs expected after its edge.
  typedef struct {
    bit rdy; bit vld; bit dat; bit lst;
    bit enc; bit se0; bit act; bit err;
  } tick_t;

  tick_t q[$];
  bit    pk[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit exp_enc = 1'b1, exp_se0 = 1'b0, exp_act = 1'b0, exp_err = 1'b0, exp_rdy = 1'b0;

  function automatic void chk1(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
    end
  endfunction

  function automatic void chk32(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endfunction

  function automatic tick_t mk(input bit rdy, input bit vld, input bit dat, input bit lst,
                               input bit enc, input bit s0, input bit act, input bit err);
    tick_t t;
    t.rdy = rdy; t.vld = vld; t.dat = dat; t.lst = lst;
    t.enc = enc; t.se0 = s0;  t.act = act; t.err = err;
    return t;
  endfunction

  // Packet bits written MSB-first: the first bit sent is v[n-1].
  function automatic void set_pkt(input logic [31:0] v, input int n);
    pk.delete();
    for (int i = 0; i < n; i++) pk.push_back(v[n-1-i]);
  endfunction

  // Reference: stuffed bit stream, NRZI line level, EOP. under < 0 ends with tx_last,
  // otherwise upstream goes silent after 'under' bits.
  task automatic model_packet(input bit b[$], input int under);
    int ones;
    bit lvl;
    int nd;
    ones = 0;
    lvl  = 1'b1;
    nd   = (under < 0) ? b.size() : under;
    for (int i = 0; i < nd; i++) begin
      lvl  = b[i] ? lvl : ~lvl;
      ones = b[i] ? ones + 1 : 0;
      q.push_back(mk(1'b1, 1'b1, b[i], (under < 0) && (i == nd - 1), lvl, 1'b0, 1'b1, 1'b0));
      if (STUFF_ON && ones == LIM) begin
        lvl  = ~lvl;
        ones = 0;
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, lvl, 1'b0, 1'b1, 1'b0));
      end
    end
    if (under >= 0) q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, lvl, 1'b0, 1'b1, 1'b1));
    for (int k = 0; k < NSE0; k++) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
  endtask

  task automatic model_idle(input int n);
    repeat (n) q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  function automatic int pack(input int n, input int f);
    int v;
    v = 0;
    for (int i = 0; i < n; i++) begin
      bit x;
      case (f)
        F_ENC:   x = q[i].enc;
        F_SE0:   x = q[i].se0;
        F_RDY:   x = q[i].rdy;
        default: x = q[i].err;
      endcase
      v = (v << 1) | int'(x);
    end
    return v;
  endfunction

  // Called at posedge+2: drive inputs for the coming edge, then record outputs expected after it.
  task automatic cycle(input bit tk, input tick_t e);
    bit_tick = tk;
    if (tk && e.rdy) begin
      tx_valid = e.vld;
      tx_bit   = e.vld ? e.dat : 1'($urandom);
      tx_last  = e.vld ? e.lst : 1'($urandom);
    end else begin
      tx_valid = 1'($urandom);
      tx_bit   = 1'($urandom);
      tx_last  = 1'($urandom);
    end
    exp_rdy = tk ? e.rdy : 1'b0;
    @(posedge clk);
    #1;
    if (tk) begin
      exp_enc = e.enc;
      exp_se0 = e.se0;
      exp_act = e.act;
      exp_err = e.err;
    end else begin
      exp_err = 1'b0;
    end
    #1;
  endtask

  task automatic run_ticks(input int n);
    tick_t e;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      e = q.pop_front();
      repeat ($urandom_range(0, 2)) cycle(1'b0, e);
      cycle(1'b1, e);
    end
  endtask

  task automatic run_queue();
    run_ticks(q.size());
  endtask

  task automatic do_reset(input int ncyc);
    nRST    = 1'b0;
    exp_enc = 1'b1;
    exp_se0 = 1'b0;
    exp_act = 1'b0;
    exp_err = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      bit_tick = (i % 2 == 0);
      tx_valid = 1'($urandom);
      tx_bit   = 1'($urandom);
      tx_last  = 1'($urandom);
      exp_rdy  = bit_tick;
      @(posedge clk);
      #2;
    end
    nRST     = 1'b1;
    bit_tick = 1'b0;
    tx_valid = 1'b0;
    exp_rdy  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("enc_bit", enc_bit, exp_enc);
      chk1("se0", se0, exp_se0);
      chk1("tx_active", tx_active, exp_act);
      chk1("tx_err", tx_err, exp_err);
      chk1("tx_ready", tx_ready, exp_rdy);
    end
  end

  int n_bits;
  int under;

  initial begin
    nRST     = 1'b0;
    bit_tick = 1'b0;
    tx_valid = 1'b0;
    tx_bit   = 1'b0;
    tx_last  = 1'b0;
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    do_reset(3);
    repeat (2) cycle(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

    // Seven zeros then a one (last)
    set_pkt(32'b0000_0001, 8);
    model_packet(pk, -1);
    chk32("model_a_enc", pack(8, F_ENC), 32'h54);
    chk32("model_a_se0", pack(11, F_SE0), 6);
    chk32("model_a_len", q.size(), 11);
    model_idle(2);
    run_queue();

    // Eight ones, last on the eighth
    set_pkt(32'hFF, 8);
    model_packet(pk, -1);
`ifdef NRZI_TX_STUFF_EN
    chk32("model_b_enc", pack(9, F_ENC), 32'h1F8);
    chk32("model_b_rdy", pack(9, F_RDY), 32'h1FB);
    chk32("model_b_len", q.size(), 12);
`else
    chk32("model_b_enc", pack(8, F_ENC), 32'hFF);
    chk32("model_b_len", q.size(), 11);
`endif
    model_idle(1);
    run_queue();

    // Six ones, last on the sixth
    set_pkt(32'h3F, 6);
    model_packet(pk, -1);
`ifdef NRZI_TX_STUFF_EN
    chk32("model_c_enc", pack(7, F_ENC), 32'h7E);
    chk32("model_c_len", q.size(), 10);
`else
    chk32("model_c_se0", pack(9, F_SE0), 6);
    chk32("model_c_len", q.size(), 9);
`endif
    model_idle(1);
    run_queue();

    // Underrun after three bits 1,0,1
    set_pkt(32'b101, 3);
    model_packet(pk, 3);
    chk32("model_d_enc", pack(4, F_ENC), 8);
    chk32("model_d_err", pack(7, F_ERR), 8);
    chk32("model_d_rdy", pack(7, F_RDY), 32'h78);
    model_idle(2);
    run_queue();

    // Reset mid-packet with five ones already sent, then a packet that would stuff early
    // if the ones count survived the reset.
    set_pkt(32'hFF, 8);
    model_packet(pk, -1);
    run_ticks(5);
    cycle(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, exp_enc, exp_se0, exp_act, 1'b0));
    do_reset(2);
    q.delete();
    set_pkt(32'b1101_1111_1100, 12);
    model_packet(pk, -1);
    model_idle(1);
    run_queue();

    // Randomised packets, ones-heavy to exercise stuffing, some underruns, some back-to-back
    for (int p = 0; p < 40; p++) begin
      n_bits = $urandom_range(1, 20);
      under  = -1;
      pk.delete();
      for (int i = 0; i < n_bits; i++) pk.push_back($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) under = $urandom_range(1, n_bits);
      model_packet(pk, under);
      model_idle($urandom_range(0, 2));
      run_queue();
    end

    model_idle(2);
    run_queue();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nrzi_stuff_encoder.md
# nrzi_stuff_encoder

USB transmit-side bit encoder: accepts a serial bit stream from the packet serializer over a per-bit valid/ready handshake, inserts a stuff bit after `STUFF_LIMIT` consecutive ones, NRZI-encodes the result, and appends the end-of-packet sequence (SE0 then J). It sits between the TX shift register and the line driver, one `bit_tick` per USB bit time, and is the transmit counterpart of the NRZI decoder on the receive path.

## Interface
- `STUFF_LIMIT`, 6, consecutive ones that force a stuff bit; range 2..15.
- `EOP_SE0_BITS`, 2, bit times of SE0 in EOP; range 1..3.
- `clk`  in  1  system clock.
- `nRST`  in  1  reset, asynchronous, active-low.
- `bit_tick`  in  1  one-cycle strobe marking one USB bit time; all state advances only on cycles with `bit_tick`=1.
- `tx_valid`  in  1  upstream has a bit on `tx_bit`.
- `tx_bit`  in  1  raw data bit (LSB-first order is upstream's job).
- `tx_last`  in  1  qualifies `tx_bit` as the last bit of the packet.
- `tx_ready`  out  1  combinational; transfer occurs on a cycle where `tx_valid & tx_ready`.
- `enc_bit`  out  1  registered NRZI line level; 1 = J/idle.
- `se0`  out  1  registered; line driver forces SE0 while high.
- `tx_active`  out  1  registered; high from the first accepted bit through the final J of EOP.
- `tx_err`  out  1  registered one-cycle pulse on underrun.

## Operation
- States: IDLE, DATA, STUFF, EOP_SE0, EOP_J.
- `tx_ready` = `bit_tick` & (state IDLE or DATA) & no pending stuff bit.
- IDLE: on transfer -> encode bit, `tx_active`=1, go DATA (or EOP path if `tx_last`).
- Encoding of an emitted bit: 0 -> `enc_bit` toggles, `ones_cnt`=0; 1 -> `enc_bit` holds, `ones_cnt`+1.
- When `ones_cnt` reaches `STUFF_LIMIT`, next `bit_tick` is a stuff cycle (STUFF): `tx_ready`=0, emit 0 (toggle), `ones_cnt`=0, return to DATA or, if last bit already taken, EOP_SE0. Stuffing applies to the final data bit too.
- DATA with `bit_tick` & !`tx_valid` (no pending stuff): underrun -> `tx_err` pulse, go EOP_SE0.
- `tx_last` transfer with no stuff pending -> EOP_SE0 on next tick.
- EOP_SE0: `se0`=1 for `EOP_SE0_BITS` ticks; `enc_bit` forced to 1.
- EOP_J: `se0`=0, `enc_bit`=1 for one tick; then IDLE, `tx_active`=0, `ones_cnt`=0.
- IDLE: `enc_bit`=1, `se0`=0; `tx_valid` ignored outside `bit_tick`.
- `ones_cnt` width = $clog2(STUFF_LIMIT+1); never exceeds `STUFF_LIMIT`.

## Timing
- Reset values: `enc_bit`=1, `se0`=0, `tx_active`=0, `tx_err`=0, state IDLE, `ones_cnt`=0; `tx_ready` follows `bit_tick` in IDLE.
- Latency: bit accepted at edge N appears on `enc_bit` after edge N, held until the next ticked edge.
- Stuff bit occupies exactly one bit time; upstream sees `tx_ready`=0 on that tick.
- First SE0 bit time begins the tick after the last data/stuff bit; EOP total = `EOP_SE0_BITS`+1 ticks.
- `nRST` low mid-packet: all outputs return to reset values immediately; no EOP emitted.
- `tx_err` high exactly one clk cycle (the cycle after the underrun tick).

## Configuration
- `NRZI_TX_STUFF_EN` defined: bit stuffing as above.
- Undefined: STUFF state and `ones_cnt` absent; `tx_ready` never deasserts for stuffing; `STUFF_LIMIT` ignored; everything else unchanged.

## Test plan
- Reset: hold `nRST` low 3 cycles, ticks running -> `enc_bit`=1, `se0`=0, `tx_active`=0, `tx_err`=0.
- Bits 0,0,0,0,0,0,0,1 (last on final) from idle -> `enc_bit` 0,1,0,1,0,1,0,0, then `se0`=1 two ticks, then `enc_bit`=1 one tick, `tx_active` drops.
- Eight ones, macro on -> `enc_bit` 1,1,1,1,1,1, stuff 0 with `tx_ready`=0 that tick, then 0,0; 9 bit times total.
- Six ones with `tx_last` on sixth -> stuff bit (toggle) emitted, then EOP; macro off -> no stuff bit, EOP directly after sixth.
- Drop `tx_valid` on a tick after 3 bits -> `tx_err` single-cycle pulse, SE0 next tick, clean return to IDLE.
- Assert `nRST` during 5th bit of a packet -> immediate `enc_bit`=1, `se0`=0; next packet encodes correctly with `ones_cnt` cleared.
